// File: rtl/tt_uart_core.sv
// 8N1 UART transceiver with a shared 16x oversample tick.
// The receive holding register carries framing-error and overrun flags.
module tt_uart_core #(
    parameter int CLK_DIV = 27,
    parameter int CNT_W   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ld_tx_data,
    input  logic [7:0] tx_data,
    input  logic       tx_enable,
    output logic       tx_out,
    output logic       tx_empty,
    input  logic       uld_rx_data,
    output logic [7:0] rx_data,
    input  logic       rx_enable,
    input  logic       rx_in,
    output logic       rx_empty,
    output logic       rx_frame_err,
    output logic       rx_overrun
);

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_WAIT,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_e;

    logic [CNT_W-1:0] div_q, div_d;
    logic             tick;

    tx_state_e  tx_state_q, tx_state_d;
    logic [3:0] tx_tcnt_q, tx_tcnt_d;
    logic [2:0] tx_idx_q, tx_idx_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic       tx_out_q, tx_out_d;
    logic       tx_empty_q, tx_empty_d;
    logic       tx_bit_end;

    logic       rx_meta_q, rx_meta_d;
    logic       rx_line_q, rx_line_d;
    rx_state_e  rx_state_q, rx_state_d;
    logic [3:0] rx_tcnt_q, rx_tcnt_d;
    logic [2:0] rx_idx_q, rx_idx_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_empty_q, rx_empty_d;
    logic       rx_fe_q, rx_fe_d;
    logic       rx_ov_q, rx_ov_d;
    logic       rx_mid;
    logic       rx_start_mid;
    logic       rx_deliver;

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q      <= '0;
            tx_state_q <= TX_IDLE;
            tx_tcnt_q  <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            tx_out_q   <= 1'b1;
            tx_empty_q <= 1'b1;
            rx_meta_q  <= 1'b1;
            rx_line_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_tcnt_q  <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_empty_q <= 1'b1;
            rx_fe_q    <= 1'b0;
            rx_ov_q    <= 1'b0;
        end else begin
            div_q      <= div_d;
            tx_state_q <= tx_state_d;
            tx_tcnt_q  <= tx_tcnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_shift_q <= tx_shift_d;
            tx_out_q   <= tx_out_d;
            tx_empty_q <= tx_empty_d;
            rx_meta_q  <= rx_meta_d;
            rx_line_q  <= rx_line_d;
            rx_state_q <= rx_state_d;
            rx_tcnt_q  <= rx_tcnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_empty_q <= rx_empty_d;
            rx_fe_q    <= rx_fe_d;
            rx_ov_q    <= rx_ov_d;
        end
    end

    always_comb begin
        tick  = (div_q == DIV_LAST);
        div_d = tick ? '0 : div_q + CNT_W'(1);
    end

    // TX next state
    always_comb begin
        tx_bit_end = tick && (tx_tcnt_q == 4'd15);
        tx_state_d = tx_state_q;
        unique case (tx_state_q)
            TX_IDLE:  if (ld_tx_data && tx_enable) tx_state_d = TX_WAIT;
            TX_WAIT:  if (tick) tx_state_d = TX_START;
            TX_START: if (tx_bit_end) tx_state_d = TX_DATA;
            TX_DATA:  if (tx_bit_end && tx_idx_q == 3'd7) tx_state_d = TX_STOP;
            TX_STOP:  if (tx_bit_end) tx_state_d = TX_IDLE;
            default:  tx_state_d = TX_IDLE;
        endcase
    end

    // TX outputs and datapath
    always_comb begin
        tx_tcnt_d  = tx_tcnt_q;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        tx_out_d   = tx_out_q;
        tx_empty_d = tx_empty_q;
        unique case (tx_state_q)
            TX_IDLE: begin
                tx_tcnt_d = '0;
                tx_idx_d  = '0;
                tx_out_d  = 1'b1;
                if (ld_tx_data && tx_enable) begin
                    tx_shift_d = tx_data;
                    tx_empty_d = 1'b0;
                end
            end
            TX_WAIT: begin
                tx_tcnt_d = '0;
                if (tick) tx_out_d = 1'b0;
            end
            TX_START: begin
                if (tick) tx_tcnt_d = tx_tcnt_q + 4'd1;
                if (tx_bit_end) begin
                    tx_out_d = tx_shift_q[0];
                    tx_idx_d = '0;
                end
            end
            TX_DATA: begin
                if (tick) tx_tcnt_d = tx_tcnt_q + 4'd1;
                if (tx_bit_end) begin
                    if (tx_idx_q == 3'd7) begin
                        tx_out_d = 1'b1;
                    end else begin
                        tx_idx_d = tx_idx_q + 3'd1;
                        tx_out_d = tx_shift_q[tx_idx_q + 3'd1];
                    end
                end
            end
            TX_STOP: begin
                if (tick) tx_tcnt_d = tx_tcnt_q + 4'd1;
                if (tx_bit_end) tx_empty_d = 1'b1;
            end
            default: begin
                tx_out_d   = 1'b1;
                tx_empty_d = 1'b1;
            end
        endcase
    end

    always_comb begin
        rx_meta_d = rx_in;
        rx_line_d = rx_meta_q;
    end

    // RX next state
    always_comb begin
        rx_mid       = tick && (rx_tcnt_q == 4'd15);
        rx_start_mid = tick && (rx_tcnt_q == 4'd7);
        rx_state_d   = rx_state_q;
        if (!rx_enable) begin
            rx_state_d = RX_IDLE;
        end else begin
            unique case (rx_state_q)
                RX_IDLE:
                    if (tick && !rx_line_q) rx_state_d = RX_START;
                RX_START:
                    if (rx_start_mid)
                        rx_state_d = rx_line_q ? RX_IDLE : RX_DATA;
                RX_DATA:
                    if (rx_mid && rx_idx_q == 3'd7) rx_state_d = RX_STOP;
                RX_STOP:
                    if (rx_mid) rx_state_d = rx_line_q ? RX_IDLE : RX_BREAK;
                RX_BREAK:
                    if (rx_line_q) rx_state_d = RX_IDLE;
                default:
                    rx_state_d = RX_IDLE;
            endcase
        end
    end

    // RX outputs and holding register
    always_comb begin
        rx_tcnt_d  = rx_tcnt_q;
        rx_idx_d   = rx_idx_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_empty_d = rx_empty_q;
        rx_fe_d    = rx_fe_q;
        rx_ov_d    = rx_ov_q;
        rx_deliver = 1'b0;
        if (!rx_enable) begin
            rx_tcnt_d = '0;
        end else begin
            unique case (rx_state_q)
                RX_START: begin
                    rx_idx_d = '0;
                    if (tick)
                        rx_tcnt_d = rx_start_mid ? 4'd0 : rx_tcnt_q + 4'd1;
                end
                RX_DATA: begin
                    if (tick) rx_tcnt_d = rx_tcnt_q + 4'd1;
                    if (rx_mid) begin
                        rx_shift_d = {rx_line_q, rx_shift_q[7:1]};
                        rx_idx_d   = rx_idx_q + 3'd1;
                    end
                end
                RX_STOP: begin
                    if (tick) rx_tcnt_d = rx_tcnt_q + 4'd1;
                    rx_deliver = rx_mid;
                end
                default: rx_tcnt_d = '0;
            endcase
        end
        if (uld_rx_data) begin
            rx_empty_d = 1'b1;
            rx_fe_d    = 1'b0;
            rx_ov_d    = 1'b0;
        end
        // An unload in the same clk retires the old byte, so no overrun.
        if (rx_deliver) begin
            rx_data_d  = rx_shift_q;
            rx_empty_d = 1'b0;
            rx_fe_d    = ~rx_line_q;
            if (!rx_empty_q && !uld_rx_data) rx_ov_d = 1'b1;
        end
    end

    assign tx_out       = tx_out_q;
    assign tx_empty     = tx_empty_q;
    assign rx_data      = rx_data_q;
    assign rx_empty     = rx_empty_q;
    assign rx_frame_err = rx_fe_q;
    assign rx_overrun   = rx_ov_q;

endmodule

// File: doc/tt_uart_core.md
Name: tt_uart_core

Overview:
- 8N1 asynchronous serial transceiver that sits directly below the DL11 console register block.
- Generates its own 16x oversample tick from the system clock.
- Serialises bytes handed over on the load/empty handshake and deserialises line input into a one-byte holding register with an unload/empty handshake.
- Adds framing-error and overrun status for the DL11 RCSR error bits.

Parameters:
- CLK_DIV, 27: system clocks per 16x oversample tick (bit time = 16*CLK_DIV clocks); legal range 2..65535.
- CNT_W, 16: width of the tick divider counter; must hold CLK_DIV-1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ld_tx_data  in  1  request to load tx_data into transmitter
- tx_data  in  8  byte to transmit
- tx_enable  in  1  transmitter enable
- tx_out  out  1  serial output, idle high
- tx_empty  out  1  transmitter idle and ready for a load
- uld_rx_data  in  1  consumer has taken rx_data
- rx_data  out  8  received byte holding register
- rx_enable  in  1  receiver enable
- rx_in  in  1  serial input, asynchronous to clk
- rx_empty  out  1  no unread byte in holding register
- rx_frame_err  out  1  last delivered byte had a bad stop bit
- rx_overrun  out  1  a byte was delivered while previous one unread

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high on port reset. All state clears immediately on reset assertion.
- Reset values: tx_out=1, tx_empty=1, rx_empty=1, rx_data=0, rx_frame_err=0, rx_overrun=0. Divider=0, both FSMs IDLE, rx synchroniser flops=1.
- Tick: divider counts 0..CLK_DIV-1 and wraps. tick is a single-clk pulse when divider==CLK_DIV-1. Free-running, shared by TX and RX.
- TX FSM states IDLE, WAIT, START, DATA, STOP. 4-bit tick counter per bit; 3-bit bit index.
  - IDLE: when ld_tx_data & tx_enable, latch tx_data, clear tx_empty next clk, go WAIT. Otherwise ld_tx_data is ignored.
  - WAIT: on next tick, go START and drive tx_out=0.
  - START: lasts 16 ticks. Then go DATA, drive bit0.
  - DATA: each bit lasts 16 ticks, LSB first. After bit7, go STOP and drive tx_out=1.
  - STOP: lasts 16 ticks. Then set tx_empty=1 and go IDLE.
  - ld_tx_data while tx_empty=0 is ignored; the latched byte is unchanged.
  - tx_enable dropping mid-frame does not abort; the frame completes.
  - Load-to-start-bit latency: 1 clk plus up to CLK_DIV clks of tick alignment.
- RX input: rx_in passes through a 2-flop synchroniser; all decisions use the synchronised value.
- RX FSM states IDLE, START, DATA, STOP, BREAK. 4-bit tick counter; 3-bit index; 8-bit shift register.
  - IDLE (requires rx_enable=1): on tick with line=0, go START with counter=0.
  - START: at tick count 7 (mid-bit), if line=0 go DATA. If line=1, treat as a glitch and return to IDLE.
  - DATA: sample every 16 ticks at mid-bit, LSB first, into the shift register. After 8 samples, go STOP.
  - STOP: sample at mid-bit, 16 ticks after bit7's sample. Deliver the byte in the same clk.
    - Delivery: rx_data<=shift, rx_empty<=0, rx_frame_err<=~line.
    - If rx_empty was already 0, rx_overrun<=1 and rx_data is overwritten.
    - Next state: IDLE if line=1, else BREAK.
  - BREAK: wait for line=1, then go IDLE. No deliveries occur while in BREAK.
  - rx_enable=0 forces IDLE from any state; no delivery. A partial frame is discarded.
- Unload: uld_rx_data sets rx_empty=1 and clears rx_frame_err and rx_overrun. Held high, it is a no-op once empty.
- Simultaneous delivery and uld_rx_data in the same clk: delivery wins. rx_empty=0, rx_overrun not set, rx_frame_err reflects the new byte.
- tx_empty and rx_empty are registered and change only on clk edges (besides reset). The consumer's "wait for deassert, then reassert" sequencing is therefore race-free.
- Reset mid-frame: tx_out returns to 1 immediately and any pending load is discarded.

Test Plan (CLK_DIV=4, bit time 64 clks):
- Reset, then a 1-clk ld_tx_data with tx_data=8'h55:
  - tx_empty=0 one clk later;
  - tx_out shows 0,1,0,1,0,1,0,1,0,1 at 64-clk intervals (start, LSB-first data, stop);
  - tx_empty=1 at 640 clks ±4 after start-bit edge.
- Drive rx_in with a 8'hA3 frame at 64 clks/bit:
  - rx_empty falls about 32 clks into the stop bit;
  - rx_data=8'hA3, rx_frame_err=0;
  - a 1-clk uld_rx_data then gives rx_empty=1.
- Send 8'h11 then 8'h22 without unloading:
  - after the second frame, rx_data=8'h22 and rx_overrun=1;
  - uld_rx_data clears both rx_empty(->1) and rx_overrun(->0).
- Send 8'h7E with the stop bit held 0 for 3 bit times:
  - delivers rx_data=8'h7E with rx_frame_err=1;
  - no second byte is delivered while the line stays low;
  - a following 8'h01 frame is received correctly.
- rx_in low pulse of 20 clks on an idle line: no delivery, and the FSM is back in IDLE; a subsequent 8'hC4 frame is received correctly.
- Assert reset mid-way through an 8'hFF transmit:
  - tx_out=1 and tx_empty=1 asynchronously;
  - after release, a new ld_tx_data of 8'h0F transmits cleanly.
